// File: rtl/result_uart_tx.sv
// ---------------------------------------------------------------------------
// result_uart_tx
// Reports each classifier decision over a UART line as a 3-byte ASCII record
// (digit, CR, LF). Results are captured on the rising edge of valid_i and
// buffered in a small FIFO so the classifier is never stalled; a full FIFO
// drops the result and raises a sticky overflow flag.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   decision_i  4-bit classifier decision
//   valid_i     decision valid (pulse or level; one accept per rising edge)
//   tx_o        UART serial out, 8N1, LSB first, idle high
//   busy_o      FIFO non-empty or a byte in flight
//   overflow_o  sticky: a result was dropped on a full FIFO
//   pending_o   number of results currently held in the FIFO
// ---------------------------------------------------------------------------
module result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    decision_i,
    input  logic                          valid_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   pending_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_UNKNOWN = 8'h3F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Decisions 0-9 become '0'-'9'; anything else is reported as '?'.
    function automatic logic [7:0] encode(input logic [3:0] d);
        if (d < 4'd10) begin
            return {4'h3, d};
        end
        return CHAR_UNKNOWN;
    endfunction

    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [1:0]      byte_idx;
    logic [7:0]      shift_reg;

    logic            valid_q;
    logic [3:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic            accept_c;
    logic            nonempty_c;
    logic            full_c;
    logic            baud_done_c;
    logic            pop_c;
    logic            push_c;
    logic            drop_c;
    logic [3:0]      head_c;

    assign accept_c    = valid_i & ~valid_q;
    assign nonempty_c  = (pending_o != '0);
    assign full_c      = (pending_o == PW'(FIFO_DEPTH));
    assign baud_done_c = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign head_c      = mem[rd_ptr];

    // Pop when leaving IDLE, or when the LF stop bit ends with more work queued.
    assign pop_c = nonempty_c &&
                   ((state == IDLE) ||
                    ((state == STOP) && baud_done_c && !(byte_idx < 2'd2)));

    // A simultaneous pop frees a slot, so a full FIFO can still take the push.
    assign push_c = accept_c && (!full_c || pop_c);
    assign drop_c = accept_c && full_c && !pop_c;

    assign busy_o = (state != IDLE) || nonempty_c;

    // Rising-edge detector on valid_i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= decision_i;
        end
    end

    // FIFO pointers, occupancy and overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pending_o  <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   pending_o <= pending_o + PW'(1);
                2'b01:   pending_o <= pending_o - PW'(1);
                default: pending_o <= pending_o;
            endcase
            if (drop_c) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Transmit FSM; tx_o is updated together with each state change so the
    // line level is registered and aligned with the bit timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            shift_reg <= '0;
            tx_o      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    tx_o     <= 1'b1;
                    if (nonempty_c) begin
                        shift_reg <= encode(head_c);
                        byte_idx  <= 2'd0;
                        tx_o      <= 1'b0;
                        state     <= START;
                    end
                end

                START: begin
                    if (baud_done_c) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_o     <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (baud_done_c) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx_o  <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            tx_o      <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (baud_done_c) begin
                        baud_cnt <= '0;
                        if (byte_idx < 2'd2) begin
                            byte_idx  <= byte_idx + 2'd1;
                            shift_reg <= (byte_idx == 2'd0) ? CHAR_CR : CHAR_LF;
                            tx_o      <= 1'b0;
                            state     <= START;
                        end else if (nonempty_c) begin
                            // Next record follows the LF stop bit with no idle gap.
                            shift_reg <= encode(head_c);
                            byte_idx  <= 2'd0;
                            tx_o      <= 1'b0;
                            state     <= START;
                        end else begin
                            tx_o  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                default: begin
                    baud_cnt <= '0;
                    tx_o     <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_result_uart_tx
// Directed bench for result_uart_tx with CLKS_PER_BIT = 4, FIFO_DEPTH = 4.
// The driver pushes the hand-computed bytes of each accepted record into a
// queue; an independent UART receiver decodes tx_o and pops/compares.
// ---------------------------------------------------------------------------
module tb_result_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [3:0] decision_i;
    logic       valid_i;
    logic       tx_o;
    logic       busy_o;
    logic       overflow_o;
    logic [2:0] pending_o;

    result_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .decision_i (decision_i),
        .valid_i    (valid_i),
        .tx_o       (tx_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o),
        .pending_o  (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    int         starts[$];
    int         rx_count = 0;
    int         pend_max = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Occupancy high-water mark.
    always @(negedge clk) begin
        if (int'(pending_o) > pend_max) pend_max = int'(pending_o);
    end

    // UART receiver: t = 0 is the first negedge of the start bit.
    bit         mon_active = 1'b0;
    int         mon_t      = 0;
    logic [7:0] mon_byte   = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx_o === 1'b0) begin
                mon_active = 1'b1;
                mon_t      = 0;
                starts.push_back(cyc);
            end
        end else begin
            mon_t++;
            if (mon_t >= 6 && mon_t <= 34 && ((mon_t - 6) % 4) == 0)
                mon_byte[(mon_t - 6) / 4] = tx_o;
            if (mon_t == 39) begin
                mon_active = 1'b0;
                rx_count++;
                check("stop_bit", 32'(tx_o), 32'd1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte (cycle %0d)", mon_byte, cyc);
                end else begin
                    check("rx_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic push_rec(input logic [7:0] digit);
        exp_q.push_back(digit);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // One-cycle valid pulse followed by one low cycle.
    task automatic pulse(input logic [3:0] d);
        decision_i = d;
        valid_i    = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) check("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

    int n;
    int low_cnt;
    int rx_before;
    int gaps_bad;

    initial begin
        rst        = 1'b0;
        valid_i    = 1'b0;
        decision_i = 4'd0;

        // 1. Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        check("rst_pending", 32'(pending_o), 32'd0);
        rst = 1'b1;
        low_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_o !== 1'b1) low_cnt++;
        end
        check("idle_tx_low_cycles", 32'(low_cnt), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);

        // 2. Single result, decision 7
        push_rec(8'h37);
        decision_i = 4'd7;
        valid_i    = 1'b1;
        @(negedge clk);
        check("single_pending_after_accept", 32'(pending_o), 32'd1);
        check("single_tx_before_start", 32'(tx_o), 32'd1);
        valid_i = 1'b0;
        @(negedge clk);
        check("single_tx_start", 32'(tx_o), 32'd0);
        check("single_pending_after_pop", 32'(pending_o), 32'd0);
        wait_idle(1000, n);
        check("single_busy_len", 32'(n), 32'd120);
        check("single_bytes_left", 32'(exp_q.size()), 32'd0);
        check("single_rx_count", 32'(rx_count), 32'd3);

        // 3. Held valid with out-of-range decision 12
        repeat (5) @(negedge clk);
        rx_before  = rx_count;
        push_rec(8'h3F);
        decision_i = 4'd12;
        valid_i    = 1'b1;
        repeat (50) @(negedge clk);
        valid_i = 1'b0;
        wait_idle(2000, n);
        repeat (10) @(negedge clk);
        check("held_rx_count", 32'(rx_count - rx_before), 32'd3);
        check("held_bytes_left", 32'(exp_q.size()), 32'd0);

        // 4. Buffered burst 1..4
        repeat (5) @(negedge clk);
        starts.delete();
        pend_max = 0;
        for (int i = 1; i <= 4; i++) begin
            push_rec(8'h30 + 8'(i));
            pulse(4'(i));
        end
        wait_idle(2000, n);
        check("burst_pending_peak", 32'(pend_max), 32'd3);
        check("burst_active_time", 32'(cyc - starts[0]), 32'd480);
        check("burst_byte_starts", 32'(starts.size()), 32'd12);
        gaps_bad = 0;
        for (int i = 1; i < starts.size(); i++)
            if (starts[i] - starts[i-1] != 40) gaps_bad++;
        check("burst_noncontiguous_gaps", 32'(gaps_bad), 32'd0);
        check("burst_overflow", 32'(overflow_o), 32'd0);
        check("burst_bytes_left", 32'(exp_q.size()), 32'd0);

        // 5. Overflow: six results 0..5, the last is dropped
        repeat (5) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) push_rec(8'h30 + 8'(i));
            decision_i = 4'(i);
            valid_i    = 1'b1;
            @(negedge clk);
            if (i == 4) check("ovf_before_sixth", 32'(overflow_o), 32'd0);
            if (i == 5) begin
                check("ovf_at_sixth", 32'(overflow_o), 32'd1);
                check("ovf_pending_full", 32'(pending_o), 32'd4);
            end
            valid_i = 1'b0;
            @(negedge clk);
        end
        wait_idle(3000, n);
        repeat (10) @(negedge clk);
        check("ovf_sticky", 32'(overflow_o), 32'd1);
        check("ovf_bytes_left", 32'(exp_q.size()), 32'd0);

        // 6. Reset during DATA of the CR byte with two results pending
        repeat (5) @(negedge clk);
        exp_q.push_back(8'h37);
        pulse(4'd7);
        pulse(4'd8);
        pulse(4'd9);
        repeat (45) @(negedge clk);
        check("mid_pending", 32'(pending_o), 32'd2);
        check("mid_tx_low_cr_bit1", 32'(tx_o), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx_o), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_post_pending", 32'(pending_o), 32'd0);
        check("mid_post_busy", 32'(busy_o), 32'd0);
        check("mid_post_overflow", 32'(overflow_o), 32'd0);
        rx_before = rx_count;
        low_cnt   = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_o !== 1'b1) low_cnt++;
        end
        check("mid_post_tx_low_cycles", 32'(low_cnt), 32'd0);
        check("mid_post_rx_count", 32'(rx_count - rx_before), 32'd0);
        check("mid_bytes_left", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
